streamer_job_sequencer: RTL and testbench

STREAMER_JOB_SEQUENCER -- requirements
Module: streamer_job_sequencer

---
 rtl/streamer_job_sequencer.sv | 145 ++++++++++++++
 tb/tb_streamer_job_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/streamer_job_sequencer.sv
// streamer_job_sequencer: runs a multi-block streaming job. For each block it
// pulses start to three sources and one sink, waits for all four done pulses,
// then advances every address by the stride.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   start_i, abort_i    job start / abort pulses
//   src_base_i          three packed source base addresses (text, key, rc)
//   sink_base_i         sink base address
//   stride_i            byte increment applied to every address per block
//   len_i, nblocks_i    words per block, blocks per job
//   src_req_start_o     per-source start pulse
//   sink_req_start_o    sink start pulse
//   src_addr_o          current packed source addresses
//   sink_addr_o         current sink address
//   trans_size_o        latched words per block
//   src_done_i          per-source done pulses
//   sink_done_i         sink done pulse
//   streamer_clear_o    streamer clear pulse
//   busy_o, done_o      job in progress / job-complete pulse
//   blk_cnt_o           blocks completed in the current or last job
module streamer_job_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [3*ADDR_W-1:0]   src_base_i,
    input  logic [ADDR_W-1:0]     sink_base_i,
    input  logic [ADDR_W-1:0]     stride_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [CNT_W-1:0]      nblocks_i,
    output logic [2:0]            src_req_start_o,
    output logic                  sink_req_start_o,
    output logic [3*ADDR_W-1:0]   src_addr_o,
    output logic [ADDR_W-1:0]     sink_addr_o,
    output logic [LEN_W-1:0]      trans_size_o,
    input  logic [2:0]            src_done_i,
    input  logic                  sink_done_i,
    output logic                  streamer_clear_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      blk_cnt_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [3*ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0]   sink_q, sink_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    nblk_q, nblk_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        sink_d   = sink_q;
        stride_d = stride_q;
        len_d    = len_q;
        nblk_d   = nblk_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (state_q == S_IDLE) begin
            // start outranks a simultaneous abort because abort is only honoured when busy
            if (start_i) begin
                src_d    = src_base_i;
                sink_d   = sink_base_i;
                stride_d = stride_i;
                len_d    = len_i;
                nblk_d   = nblocks_i;
                cnt_d    = '0;
                state_d  = (nblocks_i == '0) ? S_DONE : S_CLEAR;
            end
        end else if (abort_i && state_q != S_ABORT) begin
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_CLEAR: state_d = S_START;
                S_START: begin
                    // dones seen while requests launch belong to no block
                    sticky_d = '0;
                    state_d  = S_WAIT;
                end
                S_WAIT: begin
                    sticky_d = sticky_q | {sink_done_i, src_done_i};
                    state_d  = (&sticky_d) ? S_NEXT : S_WAIT;
                end
                S_NEXT: begin
                    cnt_d  = cnt_inc;
                    sink_d = sink_q + stride_q;
                    for (int k = 0; k < 3; k++)
                        src_d[k*ADDR_W +: ADDR_W] = src_q[k*ADDR_W +: ADDR_W] + stride_q;
                    state_d = (cnt_inc == nblk_q) ? S_DONE : S_START;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            sink_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            nblk_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            sink_q   <= sink_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            nblk_q   <= nblk_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign src_req_start_o  = {3{state_q == S_START}};
    assign sink_req_start_o = state_q == S_START;
    assign streamer_clear_o = state_q == S_CLEAR || state_q == S_ABORT;
    assign busy_o           = state_q != S_IDLE;
    assign done_o           = state_q == S_DONE;
    assign src_addr_o       = src_q;
    assign sink_addr_o      = sink_q;
    assign trans_size_o     = len_q;
    assign blk_cnt_o        = cnt_q;
endmodule

// File: tb/tb_streamer_job_sequencer.sv
// tb_streamer_job_sequencer: directed vector table plus hand sequences for the job sequencer.
module tb_streamer_job_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, abort_i, sink_done_i;
    logic [95:0] src_base_i;
    logic [31:0] sink_base_i, stride_i;
    logic [15:0] len_i, nblocks_i;
    logic [2:0]  src_done_i, src_req_start_o;
    logic        sink_req_start_o, streamer_clear_o, busy_o, done_o;
    logic [95:0] src_addr_o;
    logic [31:0] sink_addr_o;
    logic [15:0] trans_size_o, blk_cnt_o;

    int errors = 0;
    int checks = 0;
    int n_s0 = 0, n_s1 = 0, n_s2 = 0, n_k = 0, n_done = 0, n_clr = 0;

    streamer_job_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .src_base_i(src_base_i), .sink_base_i(sink_base_i), .stride_i(stride_i),
        .len_i(len_i), .nblocks_i(nblocks_i),
        .src_req_start_o(src_req_start_o), .sink_req_start_o(sink_req_start_o),
        .src_addr_o(src_addr_o), .sink_addr_o(sink_addr_o), .trans_size_o(trans_size_o),
        .src_done_i(src_done_i), .sink_done_i(sink_done_i),
        .streamer_clear_o(streamer_clear_o), .busy_o(busy_o), .done_o(done_o),
        .blk_cnt_o(blk_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        n_s0   += int'(src_req_start_o[0]);
        n_s1   += int'(src_req_start_o[1]);
        n_s2   += int'(src_req_start_o[2]);
        n_k    += int'(sink_req_start_o);
        n_done += int'(done_o);
        n_clr  += int'(streamer_clear_o);
    end

    typedef struct {
        logic        start;
        logic        abort;
        logic [2:0]  sd;
        logic        kd;
        logic        clr;
        logic [2:0]  sreq;
        logic        kreq;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
        logic [31:0] a0;
    } vec_t;

    vec_t vec [13];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_job(input int nb, input logic [31:0] b0, input logic [31:0] str);
        src_base_i  = {32'h300, 32'h200, b0};
        sink_base_i = 32'h400;
        stride_i    = str;
        len_i       = 16'd8;
        nblocks_i   = 16'(nb);
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20 && src_req_start_o != 3'b111; i++) tick();
        chk("start_seen", 64'(src_req_start_o), 64'(3'b111));
    endtask

    task automatic serve_block(input logic [31:0] ea, input logic [31:0] ek);
        wait_start();
        chk("blk_src0_addr", 64'(src_addr_o[31:0]), 64'(ea));
        chk("blk_sink_addr", 64'(sink_addr_o), 64'(ek));
        tick();
        tick();
        src_done_i  = 3'b111;
        sink_done_i = 1'b1;
        tick();
        src_done_i  = 3'b000;
        sink_done_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done_o; i++) tick();
        chk("done_seen", 64'(done_o), 64'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b_s0, b_s1, b_s2, b_k, b_d, b_c;
        // single block: inputs applied in cycle T+i, outputs expected in cycle T+i+1
        vec[0]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0, 32'h100};
        vec[1]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 16'd0, 32'h100};
        vec[2]  = '{1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0, 32'h100};
        for (int i = 3; i < 10; i++)
            vec[i] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0, 32'h100};
        vec[5].start = 1'b1;
        vec[10] = '{1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 16'd0, 32'h100};
        vec[11] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 16'd1, 32'h120};
        vec[12] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'd1, 32'h120};

        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        src_done_i = 3'b000; sink_done_i = 1'b0;
        src_base_i = {32'h300, 32'h200, 32'h100};
        sink_base_i = 32'h400; stride_i = 32'h20; len_i = 16'd8; nblocks_i = 16'd1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("rst_ctrl", 64'({busy_o, streamer_clear_o, done_o, src_req_start_o, sink_req_start_o, blk_cnt_o}), 64'(0));
        chk("rst_src_lo", src_addr_o[63:0], 64'(0));
        chk("rst_src_hi", 64'({src_addr_o[95:64], sink_addr_o}), 64'(0));
        chk("rst_len", 64'(trans_size_o), 64'(0));

        for (int i = 0; i < 13; i++) begin
            start_i = vec[i].start;
            abort_i = vec[i].abort;
            src_done_i = vec[i].sd;
            sink_done_i = vec[i].kd;
            tick();
            chk($sformatf("vec%0d", i),
                64'({streamer_clear_o, src_req_start_o, sink_req_start_o, busy_o, done_o, blk_cnt_o, src_addr_o[31:0]}),
                64'({vec[i].clr, vec[i].sreq, vec[i].kreq, vec[i].busy, vec[i].done, vec[i].cnt, vec[i].a0}));
        end
        start_i = 1'b0; abort_i = 1'b0; src_done_i = 3'b000; sink_done_i = 1'b0;
        chk("len_latched", 64'(trans_size_o), 64'(16'd8));
        chk("sink_after_1", 64'(sink_addr_o), 64'(32'h420));
        chk("src2_after_1", 64'(src_addr_o[95:64]), 64'(32'h320));

        // three blocks, stride 0x20
        b_s0 = n_s0; b_s1 = n_s1; b_s2 = n_s2; b_k = n_k; b_d = n_done;
        start_job(3, 32'h100, 32'h20);
        for (int b = 0; b < 3; b++)
            serve_block(32'h100 + 32'(b) * 32'h20, 32'h400 + 32'(b) * 32'h20);
        wait_done();
        tick();
        chk("three_cnt", 64'(blk_cnt_o), 64'(3));
        chk("three_starts", 64'({n_s0 - b_s0, n_s1 - b_s1}), {32'd3, 32'd3});
        chk("three_starts2", 64'({n_s2 - b_s2, n_k - b_k}), {32'd3, 32'd3});
        chk("three_dones", 64'(n_done - b_d), 64'(1));

        // staggered dones relative to the START cycle S, plus dones during START
        start_job(1, 32'h100, 32'h20);
        tick();
        chk("stag_start", 64'(src_req_start_o), 64'(3'b111));
        src_done_i = 3'b111; sink_done_i = 1'b1;
        tick();
        for (int i = 1; i <= 9; i++) begin
            src_done_i  = {i == 9, i == 5, i == 3 || i == 4};
            sink_done_i = i == 9;
            tick();
            chk($sformatf("stag_wait%0d", i), 64'(done_o), 64'(0));
        end
        src_done_i = 3'b000; sink_done_i = 1'b0;
        tick();
        chk("stag_done", 64'({done_o, blk_cnt_o}), 64'({1'b1, 16'd1}));
        tick();

        // address wrap
        start_job(2, 32'hFFFF_FFF0, 32'h20);
        serve_block(32'hFFFF_FFF0, 32'h400);
        serve_block(32'h0000_0010, 32'h420);
        wait_done();
        chk("wrap_cnt", 64'(blk_cnt_o), 64'(2));
        tick();

        // zero-block job: DONE the cycle after acceptance, no requests
        b_s0 = n_s0; b_c = n_clr;
        start_job(0, 32'h100, 32'h20);
        chk("zero_done", 64'({done_o, streamer_clear_o, src_req_start_o}), 64'({1'b1, 1'b0, 3'b000}));
        tick();
        chk("zero_idle", 64'({busy_o, done_o, blk_cnt_o}), 64'(0));
        chk("zero_nostart", 64'({n_s0 - b_s0, n_clr - b_c}), 64'(0));

        // abort in WAIT of block 2
        b_d = n_done; b_c = n_clr;
        start_job(3, 32'h100, 32'h20);
        serve_block(32'h100, 32'h400);
        wait_start();
        tick();
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_clr", 64'({streamer_clear_o, busy_o, done_o}), 64'(3'b110));
        tick();
        chk("abort_idle", 64'({streamer_clear_o, busy_o, blk_cnt_o}), 64'({2'b00, 16'd1}));
        tick();
        tick();
        chk("abort_counts", 64'({n_done - b_d, n_clr - b_c}), {32'd0, 32'd2});
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_idle_ignored", 64'({streamer_clear_o, busy_o, blk_cnt_o}), 64'({2'b00, 16'd1}));

        // reset mid-WAIT, then a fresh job
        start_job(2, 32'h100, 32'h20);
        wait_start();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk("midrst_ctrl", 64'({busy_o, streamer_clear_o, done_o, src_req_start_o, sink_req_start_o, blk_cnt_o, trans_size_o}), 64'(0));
        chk("midrst_addr", src_addr_o[63:0], 64'(0));
        chk("midrst_addr2", 64'({src_addr_o[95:64], sink_addr_o}), 64'(0));
        rst_i = 1'b0;
        tick();
        start_job(1, 32'h100, 32'h20);
        chk("post_rst_clear", 64'({streamer_clear_o, busy_o}), 64'(2'b11));
        serve_block(32'h100, 32'h400);
        wait_done();
        chk("post_rst_cnt", 64'(blk_cnt_o), 64'(1));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
